// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multi-cycle control FSM and the ALU-control
// decoder: state encodings, supported opcodes, ALUOp codes and aluSrcB codes.
// No ports (package). Keep this the single source of truth for these codes.
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_OR    = 2'b11;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  function automatic logic is_legal_op(input logic [5:0] op_v);
    logic legal;
    legal = 1'b0;
    case (op_v)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ORI: legal = 1'b1;
      default:                                legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// -----------------------------------------------------------------------------
// mem_wait_timer
// Counts cycles a memory request has been outstanding and flags the cycle on
// which the request has waited MEM_TIMEOUT cycles. MEM_TIMEOUT = 0 disables.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         restart the count (new access begins next cycle)
//   inc_i         request pending and not acknowledged this cycle
//   timeout_o     this is the last allowed waiting cycle
// -----------------------------------------------------------------------------
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign timeout_o = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Multi-cycle control FSM for the CPU datapath (R-type, LW, SW, BEQ, ORI).
// Sequences FETCH/DECODE/EXEC/MEM/WB and drives every datapath select.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   run                    level enable sampled at IDLE and at retire
//   op[5:0]                instruction-register opcode bits
//   aluZero                ALU zero flag (BEQ)
//   memAck / memReq,memWr  unified memory port handshake
//   iorD, irWr, pcWr, pcSrc, aluSrcA, aluSrcB, aluOpSig, regDstSig,
//   regWrSig, memToReg     datapath selects/enables
//   done, illegal, fault   one-cycle event pulses
//   state[2:0]             current state for debug
// Optional: define MULTICYCLE_CTRL_PERF_EN to add retired[31:0] and
// cycles[31:0] performance counters.
// -----------------------------------------------------------------------------
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [5:0] op,
  input  logic       aluZero,
  input  logic       memAck,
  output logic       memReq,
  output logic       memWr,
  output logic       iorD,
  output logic       irWr,
  output logic       pcWr,
  output logic       pcSrc,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOpSig,
  output logic       regDstSig,
  output logic       regWrSig,
  output logic       memToReg,
  output logic       done,
  output logic       illegal,
  output logic       fault,
  output logic [2:0] state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [31:0] retired,
  output logic [31:0] cycles
`endif
);

  state_e     state_q, state_d;
  logic [5:0] opreg_q, opreg_d;
  logic       retire;
  logic       tmo;
  logic       wait_clr;

  always_comb begin
    state_d   = state_q;
    opreg_d   = opreg_q;
    retire    = 1'b0;
    memReq    = 1'b0;
    memWr     = 1'b0;
    iorD      = 1'b0;
    irWr      = 1'b0;
    pcWr      = 1'b0;
    pcSrc     = 1'b0;
    aluSrcA   = 1'b0;
    aluSrcB   = SRCB_RT;
    aluOpSig  = ALUOP_ADD;
    regDstSig = 1'b0;
    regWrSig  = 1'b0;
    memToReg  = 1'b0;
    done      = 1'b0;
    illegal   = 1'b0;
    fault     = 1'b0;

    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;

      S_FETCH: begin
        memReq  = 1'b1;
        aluSrcB = SRCB_FOUR;
        if (memAck) begin
          irWr    = 1'b1;
          pcWr    = 1'b1;
          state_d = S_DECODE;
        end else if (tmo) begin
          // Ack on the last allowed cycle is handled above and wins.
          fault   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_DECODE: begin
        opreg_d = op;
        aluSrcB = SRCB_IMM_SH2;  // ALU forms the branch target speculatively
        if (is_legal_op(op)) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = run ? S_FETCH : S_IDLE;
        end
      end

      S_EXEC: begin
        aluSrcA = 1'b1;
        case (opreg_q)
          OP_RTYPE: begin
            aluSrcB  = SRCB_RT;
            aluOpSig = ALUOP_FUNCT;
            state_d  = S_WB;
          end
          OP_LW, OP_SW: begin
            aluSrcB  = SRCB_IMM;
            aluOpSig = ALUOP_ADD;
            state_d  = S_MEM;
          end
          OP_ORI: begin
            aluSrcB  = SRCB_IMM;
            aluOpSig = ALUOP_OR;
            state_d  = S_WB;
          end
          OP_BEQ: begin
            aluSrcB  = SRCB_RT;
            aluOpSig = ALUOP_SUB;
            pcSrc    = 1'b1;
            pcWr     = aluZero;
            retire   = 1'b1;
          end
          default: state_d = S_IDLE;
        endcase
      end

      S_MEM: begin
        memReq = 1'b1;
        iorD   = 1'b1;
        memWr  = (opreg_q == OP_SW);
        if (memAck) begin
          if (opreg_q == OP_SW) retire  = 1'b1;
          else                  state_d = S_WB;
        end else if (tmo) begin
          fault   = 1'b1;
          state_d = S_IDLE;
        end
      end

      S_WB: begin
        regWrSig  = 1'b1;
        regDstSig = (opreg_q == OP_RTYPE);
        memToReg  = (opreg_q == OP_LW);
        retire    = 1'b1;
      end

      default: state_d = S_IDLE;  // unused encodings 6/7
    endcase

    if (retire) begin
      done    = 1'b1;
      state_d = run ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      opreg_q <= '0;
    end else begin
      state_q <= state_d;
      opreg_q <= opreg_d;
    end
  end

  // Restart the wait count whenever a new memory access begins.
  assign wait_clr = (state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .CNT_W      (CNT_W)
  ) u_wait (
    .clk_i    (clk),
    .rst_i    (rst),
    .clr_i    (wait_clr),
    .inc_i    (memReq && !memAck),
    .timeout_o(tmo)
  );

  assign state = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] retired_q, cycles_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_q <= '0;
      cycles_q  <= '0;
    end else begin
      if (done)              retired_q <= retired_q + 32'd1;
      if (state_q != S_IDLE) cycles_q  <= cycles_q + 32'd1;
    end
  end

  assign retired = retired_q;
  assign cycles  = cycles_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Directed, table-driven bench for multicycle_ctrl built with MEM_TIMEOUT=4.
// Each table row is one clock cycle: inputs applied after the rising edge,
// the full output vector compared mid-cycle against a hand-derived value.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic [5:0] op;
  logic       aluZero;
  logic       memAck;
  logic       memReq, memWr, iorD, irWr, pcWr, pcSrc, aluSrcA;
  logic [1:0] aluSrcB, aluOpSig;
  logic       regDstSig, regWrSig, memToReg, done, illegal, fault;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .run(run), .op(op), .aluZero(aluZero), .memAck(memAck),
    .memReq(memReq), .memWr(memWr), .iorD(iorD), .irWr(irWr), .pcWr(pcWr),
    .pcSrc(pcSrc), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOpSig(aluOpSig),
    .regDstSig(regDstSig), .regWrSig(regWrSig), .memToReg(memToReg),
    .done(done), .illegal(illegal), .fault(fault), .state(state)
  );

  // {state, memReq, memWr, iorD, irWr, pcWr, pcSrc, aluSrcA, aluSrcB, aluOp,
  //  regDst, regWr, memToReg, done, illegal, fault}
  logic [19:0] obs;
  assign obs = {state, memReq, memWr, iorD, irWr, pcWr, pcSrc, aluSrcA, aluSrcB,
                aluOpSig, regDstSig, regWrSig, memToReg, done, illegal, fault};

  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, ORI = 6'b001101, BAD = 6'b111111;

  function automatic logic [19:0] x_idle();
    return 20'h0;
  endfunction
  function automatic logic [19:0] x_fetch(input logic ack, input logic flt);
    return {3'd1, 1'b1, 1'b0, 1'b0, ack, ack, 1'b0, 1'b0, 2'b01, 2'b00,
            1'b0, 1'b0, 1'b0, 1'b0, 1'b0, flt};
  endfunction
  function automatic logic [19:0] x_decode(input logic ill);
    return {3'd2, 7'b0, 2'b11, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, ill, 1'b0};
  endfunction
  function automatic logic [19:0] x_exec(input logic [1:0] srcb, input logic [1:0] aop,
                                         input logic psrc, input logic pwr, input logic dn);
    return {3'd3, 1'b0, 1'b0, 1'b0, 1'b0, pwr, psrc, 1'b1, srcb, aop,
            1'b0, 1'b0, 1'b0, dn, 1'b0, 1'b0};
  endfunction
  function automatic logic [19:0] x_mem(input logic wr, input logic dn, input logic flt);
    return {3'd4, 1'b1, wr, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00,
            1'b0, 1'b0, 1'b0, dn, 1'b0, flt};
  endfunction
  function automatic logic [19:0] x_wb(input logic rdst, input logic m2r);
    return {3'd5, 7'b0, 2'b00, 2'b00, rdst, 1'b1, m2r, 1'b1, 1'b0, 1'b0};
  endfunction

  typedef struct {
    logic        run;
    logic [5:0]  op;
    logic        zero;
    logic        ack;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [5:0] o, input logic z, input logic a,
                     input logic [19:0] e);
    vec_t v;
    v.run = r; v.op = o; v.zero = z; v.ack = a; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [19:0] act, input logic [19:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; run = 1'b0; op = '0; aluZero = 1'b0; memAck = 1'b0;

    //   run op   zero ack  expected
    // R-type, immediate fetch ack
    add(1, R,   0, 1, x_idle());                        // 0 IDLE, ack ignored
    add(1, R,   0, 1, x_fetch(1, 0));                   // 1
    add(1, R,   0, 0, x_decode(0));                     // 2
    add(1, R,   0, 0, x_exec(2'b00, 2'b10, 0, 0, 0));   // 3
    add(1, R,   0, 0, x_wb(1, 0));                      // 4 done
    // LW with ack on 3rd MEM cycle
    add(1, LW,  0, 1, x_fetch(1, 0));                   // 5
    add(1, LW,  0, 0, x_decode(0));                     // 6
    add(1, LW,  0, 0, x_exec(2'b10, 2'b00, 0, 0, 0));   // 7
    add(1, LW,  0, 0, x_mem(0, 0, 0));                  // 8
    add(1, LW,  0, 0, x_mem(0, 0, 0));                  // 9
    add(1, LW,  0, 1, x_mem(0, 0, 0));                  // 10
    add(1, LW,  0, 0, x_wb(0, 1));                      // 11
    // BEQ taken then not taken
    add(1, BEQ, 0, 1, x_fetch(1, 0));                   // 12
    add(1, BEQ, 0, 0, x_decode(0));                     // 13
    add(1, BEQ, 1, 0, x_exec(2'b00, 2'b01, 1, 1, 1));   // 14
    add(1, BEQ, 0, 1, x_fetch(1, 0));                   // 15
    add(1, BEQ, 0, 0, x_decode(0));                     // 16
    add(1, BEQ, 0, 0, x_exec(2'b00, 2'b01, 1, 0, 1));   // 17
    // ORI
    add(1, ORI, 0, 1, x_fetch(1, 0));                   // 18
    add(1, ORI, 0, 0, x_decode(0));                     // 19
    add(1, ORI, 0, 0, x_exec(2'b10, 2'b11, 0, 0, 0));   // 20
    add(1, ORI, 0, 0, x_wb(0, 0));                      // 21
    // SW retires in MEM
    add(1, SW,  0, 1, x_fetch(1, 0));                   // 22
    add(1, SW,  0, 0, x_decode(0));                     // 23
    add(1, SW,  0, 0, x_exec(2'b10, 2'b00, 0, 0, 0));   // 24
    add(1, SW,  0, 1, x_mem(1, 1, 0));                  // 25
    // Illegal opcode: back to FETCH, then to IDLE with run low
    add(1, BAD, 0, 1, x_fetch(1, 0));                   // 26
    add(1, BAD, 0, 0, x_decode(1));                     // 27
    add(1, BAD, 0, 1, x_fetch(1, 0));                   // 28
    add(0, BAD, 0, 0, x_decode(1));                     // 29
    add(0, R,   0, 1, x_idle());                        // 30
    add(0, R,   0, 0, x_idle());                        // 31
    // run dropped mid-instruction does not abort
    add(1, R,   0, 0, x_idle());                        // 32
    add(0, R,   0, 1, x_fetch(1, 0));                   // 33
    add(0, R,   0, 0, x_decode(0));                     // 34
    add(0, R,   0, 0, x_exec(2'b00, 2'b10, 0, 0, 0));   // 35
    add(0, R,   0, 0, x_wb(1, 0));                      // 36
    add(0, R,   0, 1, x_idle());                        // 37
    // LW: ack on the timeout cycle beats fault
    add(1, LW,  0, 0, x_idle());                        // 38
    add(0, LW,  0, 1, x_fetch(1, 0));                   // 39
    add(0, LW,  0, 0, x_decode(0));                     // 40
    add(0, LW,  0, 0, x_exec(2'b10, 2'b00, 0, 0, 0));   // 41
    add(0, LW,  0, 0, x_mem(0, 0, 0));                  // 42
    add(0, LW,  0, 0, x_mem(0, 0, 0));                  // 43
    add(0, LW,  0, 0, x_mem(0, 0, 0));                  // 44
    add(0, LW,  0, 1, x_mem(0, 0, 0));                  // 45
    add(0, LW,  0, 0, x_wb(0, 1));                      // 46
    add(0, LW,  0, 0, x_idle());                        // 47
    // SW: no ack in MEM -> fault on 4th cycle, no retire
    add(1, SW,  0, 0, x_idle());                        // 48
    add(0, SW,  0, 1, x_fetch(1, 0));                   // 49
    add(0, SW,  0, 0, x_decode(0));                     // 50
    add(0, SW,  0, 0, x_exec(2'b10, 2'b00, 0, 0, 0));   // 51
    add(0, SW,  0, 0, x_mem(1, 0, 0));                  // 52
    add(0, SW,  0, 0, x_mem(1, 0, 0));                  // 53
    add(0, SW,  0, 0, x_mem(1, 0, 0));                  // 54
    add(0, SW,  0, 0, x_mem(1, 0, 1));                  // 55
    add(0, SW,  0, 0, x_idle());                        // 56

    // Reset state
    step();
    step();
    chk("reset_outputs", obs, x_idle());
    rst = 1'b0;

    foreach (tbl[i]) begin
      run = tbl[i].run; op = tbl[i].op; aluZero = tbl[i].zero; memAck = tbl[i].ack;
      #4;
      chk($sformatf("vec%0d", i), obs, tbl[i].exp);
      step();
    end

    // FETCH timeout: memAck never arrives
    run = 1'b1; op = R; aluZero = 1'b0; memAck = 1'b0;
    #4; chk("tmo_idle", obs, x_idle());
    step();
    run = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      #4; chk($sformatf("tmo_fetch%0d", k), obs, x_fetch(1'b0, k == 4));
      step();
    end
    #4; chk("tmo_back_idle", obs, x_idle());
    step();

    // Async reset in the middle of an SW memory access
    run = 1'b1; op = SW; memAck = 1'b0;
    step();
    run = 1'b0; memAck = 1'b1;
    step();
    memAck = 1'b0;
    step();
    step();
    #4; chk("rst_pre_mem", obs, x_mem(1'b1, 1'b0, 1'b0));
    #1; rst = 1'b1;
    #1; chk("rst_async_drop", obs, x_idle());
    step();
    rst = 1'b0; run = 1'b1;
    #4; chk("rst_release_idle", obs, x_idle());
    step();
    #4; chk("rst_resume_fetch", obs, x_fetch(1'b0, 1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
